// File: rtl/food_placer.sv
// Food placement engine: folds random candidates into the grid, checks snake occupancy,
// retries a bounded number of times, then falls back to a linear scan of the grid.
module food_placer #(
  parameter int unsigned GRID_W    = 32,
  parameter int unsigned GRID_H    = 24,
  parameter int unsigned MAX_TRIES = 8,
  localparam int unsigned HW       = $clog2(GRID_W),
  localparam int unsigned VW       = $clog2(GRID_H),
  localparam int unsigned TW       = $clog2(MAX_TRIES + 1),
  localparam int unsigned CW       = $clog2(GRID_W * GRID_H + 1)
) (
  input  logic          MasterClock,
  input  logic          reset,
  input  logic          PlaceReq,
  input  logic [VW-1:0] NextFoodV,
  input  logic [HW-1:0] NextFoodH,
  output logic [VW-1:0] OccQueryV,
  output logic [HW-1:0] OccQueryH,
  output logic          OccQueryValid,
  input  logic          OccBusy,
  output logic [VW-1:0] FoodV,
  output logic [HW-1:0] FoodH,
  output logic          FoodValid,
  output logic          Busy,
  output logic          Placed,
  output logic          GridFull
);

  localparam int unsigned Cells = GRID_W * GRID_H;
  localparam bit WPow2 = ((GRID_W & (GRID_W - 1)) == 0);
  localparam bit HPow2 = ((GRID_H & (GRID_H - 1)) == 0);

  typedef enum logic [2:0] {StIdle, StRQuery, StRCheck, StSQuery, StSCheck} state_e;

  state_e        state_q, state_d;
  logic [VW-1:0] qv_q, qv_d;
  logic [HW-1:0] qh_q, qh_d;
  logic [TW-1:0] tries_q, tries_d;
  logic [CW-1:0] scanned_q, scanned_d;
  logic [VW-1:0] food_v_q, food_v_d;
  logic [HW-1:0] food_h_q, food_h_d;
  logic          food_valid_q, food_valid_d;
  logic          grid_full_q, grid_full_d;
  logic          placed_q, placed_d;
  logic [VW-1:0] fold_v;
  logic [HW-1:0] fold_h;

  // Candidates are at most one grid span out of range, so one subtraction folds them.
  always_comb begin
    fold_v = NextFoodV;
    fold_h = NextFoodH;
    if (!HPow2 && ({1'b0, NextFoodV} >= (VW + 1)'(GRID_H))) fold_v = NextFoodV - VW'(GRID_H);
    if (!WPow2 && ({1'b0, NextFoodH} >= (HW + 1)'(GRID_W))) fold_h = NextFoodH - HW'(GRID_W);
  end

  always_comb begin
    state_d      = state_q;
    qv_d         = qv_q;
    qh_d         = qh_q;
    tries_d      = tries_q;
    scanned_d    = scanned_q;
    food_v_d     = food_v_q;
    food_h_d     = food_h_q;
    food_valid_d = food_valid_q;
    grid_full_d  = grid_full_q;
    placed_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (PlaceReq) begin
          food_valid_d = 1'b0;
          grid_full_d  = 1'b0;
          tries_d      = '0;
          state_d      = StRQuery;
        end
      end
      StRQuery: begin
        qv_d    = fold_v;
        qh_d    = fold_h;
        tries_d = tries_q + TW'(1);
        state_d = StRCheck;
      end
      StRCheck: begin
        if (!OccBusy) begin
          food_v_d     = qv_q;
          food_h_d     = qh_q;
          food_valid_d = 1'b1;
          placed_d     = 1'b1;
          state_d      = StIdle;
        end else if (tries_q < TW'(MAX_TRIES)) begin
          state_d = StRQuery;
        end else begin
          // The last random cell already counts as one scanned cell.
          scanned_d = CW'(1);
          state_d   = StSQuery;
        end
      end
      StSQuery: begin
        if (qh_q == HW'(GRID_W - 1)) begin
          qh_d = '0;
          qv_d = (qv_q == VW'(GRID_H - 1)) ? '0 : qv_q + VW'(1);
        end else begin
          qh_d = qh_q + HW'(1);
        end
        scanned_d = scanned_q + CW'(1);
        state_d   = StSCheck;
      end
      StSCheck: begin
        if (!OccBusy) begin
          food_v_d     = qv_q;
          food_h_d     = qh_q;
          food_valid_d = 1'b1;
          placed_d     = 1'b1;
          state_d      = StIdle;
        end else if (scanned_q < CW'(Cells)) begin
          state_d = StSQuery;
        end else begin
          grid_full_d  = 1'b1;
          food_valid_d = 1'b0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge MasterClock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      qv_q         <= '0;
      qh_q         <= '0;
      tries_q      <= '0;
      scanned_q    <= '0;
      food_v_q     <= '0;
      food_h_q     <= '0;
      food_valid_q <= 1'b0;
      grid_full_q  <= 1'b0;
      placed_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      qv_q         <= qv_d;
      qh_q         <= qh_d;
      tries_q      <= tries_d;
      scanned_q    <= scanned_d;
      food_v_q     <= food_v_d;
      food_h_q     <= food_h_d;
      food_valid_q <= food_valid_d;
      grid_full_q  <= grid_full_d;
      placed_q     <= placed_d;
    end
  end

  // The address is presented during the query cycle and held by the register through the check.
  assign OccQueryV     = qv_d;
  assign OccQueryH     = qh_d;
  assign OccQueryValid = (state_q == StRQuery) || (state_q == StSQuery);
  assign Busy          = (state_q != StIdle);
  assign FoodV         = food_v_q;
  assign FoodH         = food_h_q;
  assign FoodValid     = food_valid_q;
  assign Placed        = placed_q;
  assign GridFull      = grid_full_q;

endmodule

// File: tb/tb_food_placer.sv
// Directed bench for food_placer on a 6x3 grid with 3 random tries; queries and commits are
// checked against a scoreboard filled as stimulus is driven.
module tb_food_placer;

  logic       MasterClock;
  logic       reset;
  logic       PlaceReq;
  logic [1:0] NextFoodV;
  logic [2:0] NextFoodH;
  logic [1:0] OccQueryV;
  logic [2:0] OccQueryH;
  logic       OccQueryValid;
  logic       OccBusy;
  logic [1:0] FoodV;
  logic [2:0] FoodH;
  logic       FoodValid;
  logic       Busy;
  logic       Placed;
  logic       GridFull;

  food_placer #(
    .GRID_W   (6),
    .GRID_H   (3),
    .MAX_TRIES(3)
  ) dut (
    .MasterClock  (MasterClock),
    .reset        (reset),
    .PlaceReq     (PlaceReq),
    .NextFoodV    (NextFoodV),
    .NextFoodH    (NextFoodH),
    .OccQueryV    (OccQueryV),
    .OccQueryH    (OccQueryH),
    .OccQueryValid(OccQueryValid),
    .OccBusy      (OccBusy),
    .FoodV        (FoodV),
    .FoodH        (FoodH),
    .FoodValid    (FoodValid),
    .Busy         (Busy),
    .Placed       (Placed),
    .GridFull     (GridFull)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;
  int qcount    = 0;

  logic [4:0] exp_q[$];
  logic       resp_q[$];
  logic [4:0] commit_q[$];
  logic [1:0] cv[8];
  logic [2:0] ch[8];
  int         ncand = 0;

  initial begin
    MasterClock = 1'b0;
    forever #5 MasterClock = ~MasterClock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [4:0] fold(input logic [1:0] v, input logic [2:0] h);
    logic [1:0] fv;
    logic [2:0] fh;
    fv = (v >= 2'd3) ? v - 2'd3 : v;
    fh = (h >= 3'd6) ? h - 3'd6 : h;
    return {fv, fh};
  endfunction

  function automatic logic [4:0] nxt(input logic [4:0] c);
    logic [1:0] v;
    logic [2:0] h;
    v = c[4:3];
    h = c[2:0];
    if (h == 3'd5) begin
      h = 3'd0;
      v = (v == 2'd2) ? 2'd0 : v + 2'd1;
    end else begin
      h = h + 3'd1;
    end
    return {v, h};
  endfunction

  task automatic add_cand(input logic [1:0] v, input logic [2:0] h, input logic b);
    cv[ncand] = v;
    ch[ncand] = h;
    ncand++;
    exp_q.push_back(fold(v, h));
    resp_q.push_back(b);
  endtask

  // Issues a request and feeds candidates; lat is the cycle (after the request edge) where
  // Placed or GridFull first appears, bcnt the number of Busy cycles before it.
  task automatic run(output int lat, output int bcnt);
    int cyc;
    bit done;
    @(negedge MasterClock);
    PlaceReq  = 1'b1;
    NextFoodV = cv[0];
    NextFoodH = ch[0];
    @(negedge MasterClock);
    PlaceReq = 1'b0;
    bcnt = 0;
    lat  = 0;
    done = 1'b0;
    for (cyc = 1; cyc < 200 && !done; cyc++) begin
      if (Busy) bcnt++;
      if (Placed || GridFull) begin
        lat  = cyc;
        done = 1'b1;
      end else begin
        if ((cyc % 2) == 0 && (cyc / 2) < ncand) begin
          NextFoodV = cv[cyc/2];
          NextFoodH = ch[cyc/2];
        end
        @(negedge MasterClock);
      end
    end
    chk("placement_finished", 32'(done), 1);
    ncand = 0;
  endtask

  // Scoreboard side: answers occupancy queries and compares addresses and commits.
  initial begin
    logic [4:0] e;
    OccBusy = 1'b0;
    forever begin
      @(negedge MasterClock);
      if (OccQueryValid) begin
        qcount++;
        chk("query_pending", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("query_addr", {27'd0, OccQueryV, OccQueryH}, {27'd0, e});
        end
        OccBusy = (resp_q.size() != 0) ? resp_q.pop_front() : 1'b1;
      end
      if (Placed) begin
        chk("commit_pending", 32'(commit_q.size() != 0), 1);
        if (commit_q.size() != 0) begin
          e = commit_q.pop_front();
          chk("commit_addr", {27'd0, FoodV, FoodH}, {27'd0, e});
        end
      end
    end
  end

  initial begin
    int lat;
    int bcnt;
    int q0;
    logic [4:0] c;
    reset     = 1'b0;
    PlaceReq  = 1'b0;
    NextFoodV = '0;
    NextFoodH = '0;
    repeat (3) @(negedge MasterClock);
    chk("reset_outputs", {22'd0, FoodV, FoodH, FoodValid, Busy, Placed, GridFull, OccQueryValid},
        0);
    reset = 1'b1;
    repeat (2) @(negedge MasterClock);
    chk("idle_outputs", {18'd0, OccQueryV, OccQueryH, FoodV, FoodH, FoodValid, Busy, Placed,
        GridFull, OccQueryValid}, 0);

    // Free first try with detailed cycle checks.
    add_cand(2'd1, 3'd4, 1'b0);
    commit_q.push_back(5'b01_100);
    @(negedge MasterClock);
    PlaceReq  = 1'b1;
    NextFoodV = cv[0];
    NextFoodH = ch[0];
    ncand = 0;
    @(negedge MasterClock);
    PlaceReq = 1'b0;
    chk("k1_busy_qvalid_fv", {29'd0, Busy, OccQueryValid, FoodValid}, 32'b110);
    @(negedge MasterClock);
    chk("k2_check_cycle", {29'd0, Busy, OccQueryValid, Placed}, 32'b100);
    chk("k2_addr_stable", {27'd0, OccQueryV, OccQueryH}, 32'b01_100);
    @(negedge MasterClock);
    chk("k3_commit", {24'd0, FoodV, FoodH, FoodValid, Placed, Busy}, {24'd0, 5'b01_100, 3'b110});
    @(negedge MasterClock);
    chk("k4_placed_pulse", 32'(Placed), 0);

    // Fold of out-of-range candidate.
    add_cand(2'd3, 3'd7, 1'b0);
    commit_q.push_back(5'b00_001);
    run(lat, bcnt);
    chk("fold_latency", lat, 3);
    chk("fold_food", {27'd0, FoodV, FoodH}, 32'b00_001);

    // Two occupied randoms, third free.
    add_cand(2'd0, 3'd0, 1'b1);
    add_cand(2'd1, 3'd2, 1'b1);
    add_cand(2'd2, 3'd5, 1'b0);
    commit_q.push_back(5'b10_101);
    run(lat, bcnt);
    chk("retry_latency", lat, 7);
    chk("retry_busy_cycles", bcnt, 6);

    // Fallback scan from (0,5) to (1,0).
    add_cand(2'd0, 3'd0, 1'b1);
    add_cand(2'd1, 3'd1, 1'b1);
    add_cand(2'd0, 3'd5, 1'b1);
    exp_q.push_back(5'b01_000);
    resp_q.push_back(1'b0);
    commit_q.push_back(5'b01_000);
    run(lat, bcnt);
    chk("scan_latency", lat, 9);
    chk("scan_food", {27'd0, FoodV, FoodH}, 32'b01_000);

    // Scan wraps from (2,5) to (0,0).
    add_cand(2'd0, 3'd1, 1'b1);
    add_cand(2'd0, 3'd2, 1'b1);
    add_cand(2'd2, 3'd5, 1'b1);
    exp_q.push_back(5'b00_000);
    resp_q.push_back(1'b0);
    commit_q.push_back(5'b00_000);
    run(lat, bcnt);
    chk("wrap_latency", lat, 9);
    chk("wrap_food", {27'd0, FoodV, FoodH}, 32'b00_000);

    // Every cell occupied.
    add_cand(2'd1, 3'd1, 1'b1);
    add_cand(2'd2, 3'd2, 1'b1);
    add_cand(2'd0, 3'd3, 1'b1);
    c = fold(2'd0, 3'd3);
    for (int i = 0; i < 17; i++) begin
      c = nxt(c);
      exp_q.push_back(c);
      resp_q.push_back(1'b1);
    end
    q0 = qcount;
    run(lat, bcnt);
    chk("full_latency", lat, 41);
    chk("full_busy_cycles", bcnt, 40);
    chk("full_query_count", qcount - q0, 20);
    chk("full_flags", {29'd0, GridFull, FoodValid, Placed}, 32'b100);
    chk("full_food_held", {27'd0, FoodV, FoodH}, 32'b00_000);
    @(negedge MasterClock);
    chk("full_held", 32'(GridFull), 1);

    // Next request clears GridFull.
    add_cand(2'd2, 3'd0, 1'b0);
    commit_q.push_back(5'b10_000);
    @(negedge MasterClock);
    PlaceReq  = 1'b1;
    NextFoodV = cv[0];
    NextFoodH = ch[0];
    ncand = 0;
    @(negedge MasterClock);
    PlaceReq = 1'b0;
    chk("gridfull_cleared", {30'd0, GridFull, Busy}, 32'b01);
    repeat (3) @(negedge MasterClock);

    // PlaceReq held through Busy is not queued.
    add_cand(2'd1, 3'd3, 1'b0);
    commit_q.push_back(5'b01_011);
    @(negedge MasterClock);
    PlaceReq  = 1'b1;
    NextFoodV = cv[0];
    NextFoodH = ch[0];
    ncand = 0;
    repeat (3) @(negedge MasterClock);
    PlaceReq = 1'b0;
    chk("ignored_req_commit", {30'd0, Placed, Busy}, 32'b10);
    @(negedge MasterClock);
    chk("ignored_req_idle", {30'd0, Busy, OccQueryValid}, 0);
    @(negedge MasterClock);
    chk("ignored_req_idle2", {30'd0, Busy, OccQueryValid}, 0);

    // Reset asserted during the check cycle.
    add_cand(2'd2, 3'd2, 1'b0);
    @(negedge MasterClock);
    PlaceReq  = 1'b1;
    NextFoodV = cv[0];
    NextFoodH = ch[0];
    ncand = 0;
    repeat (2) @(negedge MasterClock);
    PlaceReq = 1'b0;
    reset    = 1'b0;
    #1;
    chk("midreset_outputs", {18'd0, OccQueryV, OccQueryH, FoodV, FoodH, FoodValid, Busy, Placed,
        GridFull, OccQueryValid}, 0);
    @(negedge MasterClock);
    reset = 1'b1;
    @(negedge MasterClock);
    chk("postreset_no_pulse", {29'd0, Placed, FoodValid, Busy}, 0);
    @(negedge MasterClock);
    chk("postreset_no_pulse2", {24'd0, FoodV, FoodH, Placed, FoodValid, Busy}, 0);

    chk("queries_drained", 32'(exp_q.size()), 0);
    chk("commits_drained", 32'(commit_q.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/food_placer.md
# food_placer

Consumes the free-running candidate coordinate produced by the food randomizer and turns it into a committed, legal food position. On each placement request it samples the candidate and folds it into grid range. It then checks the cell against the snake-occupancy lookup and retries with fresh random candidates. If the retry budget runs out, it falls back to a deterministic linear scan. It sits between the randomizer and the game-state/renderer logic, and is the sole owner of the current food position.

## Interface
- GRID_W, 32, grid width in cells; top level overrides with `GRID_WIDTH from Constants.v
- GRID_H, 24, grid height in cells; top level overrides with `GRID_HEIGHT
- MAX_TRIES, 8, random attempts before falling back to linear scan; must be ≥1
- Derived widths: HW = $clog2(GRID_W), VW = $clog2(GRID_H), TW = $clog2(MAX_TRIES+1), CW = $clog2(GRID_W*GRID_H+1)

- MasterClock  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-low; all registers cleared while low
- PlaceReq  in  1  one-cycle request for new food (game start or food eaten)
- NextFoodV  in  VW  random row candidate; may change every cycle
- NextFoodH  in  HW  random column candidate; may change every cycle
- OccQueryV  out  VW  row being checked
- OccQueryH  out  HW  column being checked
- OccQueryValid  out  1  query address is valid this cycle
- OccBusy  in  1  cell occupied by snake; valid exactly one cycle after OccQueryValid
- FoodV  out  VW  committed food row
- FoodH  out  HW  committed food column
- FoodValid  out  1  committed position is current
- Busy  out  1  placement in progress
- Placed  out  1  one-cycle pulse on commit
- GridFull  out  1  no free cell found; held until next accepted PlaceReq

## Operation
- States: IDLE, RQUERY, RCHECK, SQUERY, SCHECK.
- IDLE: Busy=0. PlaceReq=1 → clear FoodValid, clear GridFull, tries=0, go RQUERY. PlaceReq while Busy=1 is ignored (not queued).
- RQUERY: latch folded candidate into the query registers; OccQueryValid=1; increment tries; go RCHECK.
- Fold rule: if NextFoodV ≥ GRID_H, use NextFoodV−GRID_H, else pass through. If NextFoodH ≥ GRID_W, use NextFoodH−GRID_W, else pass through. One subtraction always suffices. Power-of-two dimensions bypass the fold.
- RCHECK: sample OccBusy.
  - Free → commit the query address to FoodV/FoodH, FoodValid=1, Placed pulse, go IDLE.
  - Occupied and tries<MAX_TRIES → RQUERY.
  - Occupied and tries==MAX_TRIES → scanned=1, go SQUERY.
- SQUERY: advance the address. H+1; if H hits GRID_W−1, H wraps to 0 and V+1. If V hits GRID_H−1 on that wrap, V wraps to 0. OccQueryValid=1; go SCHECK.
- SCHECK: sample OccBusy.
  - Free → commit as above.
  - Occupied and scanned<GRID_W*GRID_H → scanned+1, SQUERY.
  - Else → GridFull=1, FoodValid=0, go IDLE.
- The scan revisits at most every cell once. The last random cell counts as scanned.
- FoodV/FoodH hold their value between commits, including while FoodValid=0.

## Timing
- Reset values: state IDLE; FoodV, FoodH, FoodValid, Busy, Placed, GridFull, OccQueryValid, OccQueryV, OccQueryH = 0.
- PlaceReq sampled high at edge k:
  - Busy=1 and FoodValid=0 from cycle k+1.
  - RQUERY occupies cycle k+1, with OccQueryValid=1.
  - RCHECK occupies cycle k+2.
  - On a free first try, FoodV/FoodH/FoodValid update and Placed=1 in cycle k+3, with Busy=0.
- Each random retry and each scan step costs 2 cycles.
- Worst case: PlaceReq to GridFull is 2·MAX_TRIES + 2·(GRID_W·GRID_H−1) + 1 cycles.
- OccQueryValid is high only in RQUERY/SQUERY cycles. Query address is stable through the following check cycle.
- reset low mid-placement: immediate return to reset values. No Placed pulse; no partial commit.

## Test plan
Bench uses GRID_W=6, GRID_H=3, MAX_TRIES=3 (HW=3, VW=2).
- Reset release, idle → all outputs 0. PlaceReq with candidate (V=1,H=4), OccBusy=0 → FoodV=1, FoodH=4, FoodValid=1, Placed pulse 3 cycles after the request edge.
- Candidate V=3, H=7, cell free → query and commit at V=0, H=1 (fold).
- First two candidates occupied, third (2,5) free → three queries, commit (2,5), 6 cycles of Busy.
- All three randoms occupied, last (0,5); (1,0) free → scan queries (1,0), commits (1,0). Then repeat from last (2,5) → scan wraps to (0,0).
- OccBusy held 1 → exactly 3+17 queries, GridFull=1, FoodValid=0. Next PlaceReq clears GridFull.
- PlaceReq during Busy → ignored. reset pulsed low in RCHECK → outputs 0, no Placed pulse.
